// File: rtl/alu_pkg.sv
// Shared ALU encodings and FSM state type for the ALU decoder and execution unit.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SLT  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_single_cycle.sv
// Combinational single-cycle ALU ops; unknown codes fall back to ADD.
module alu_single_cycle
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  // Shift codes never reach this result; they land in the default arm harmlessly.
  always_comb begin
    y = a + b;
    case (ctrl)
      ALU_SUB:  y = a - b;
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle ops plus bit-serial shifts, valid/ready on both sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  alu_state_e         state, state_nxt;
  logic [XLEN-1:0]    sh_reg, sh_nxt, alu_y;
  logic [SHAMT_W-1:0] cnt;
  logic [3:0]         sh_op;
  logic               accept;
  logic [SHAMT_W-1:0] shamt;

  assign accept = in_valid && (state == ST_IDLE);
  assign shamt  = SrcB[SHAMT_W-1:0];

  alu_single_cycle #(.XLEN(XLEN)) u_single (
    .ctrl (ALUControl),
    .a    (SrcA),
    .b    (SrcB),
    .y    (alu_y)
  );

  // One-bit step of the captured shift operation.
  always_comb begin
    sh_nxt = {sh_reg[XLEN-2:0], 1'b0};
    case (sh_op)
      ALU_SRL: sh_nxt = {1'b0, sh_reg[XLEN-1:1]};
      ALU_SRA: sh_nxt = {sh_reg[XLEN-1], sh_reg[XLEN-1:1]};
      default: sh_nxt = {sh_reg[XLEN-2:0], 1'b0};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: zero-length shifts finish like single-cycle ops.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = (is_shift(ALUControl) && shamt != '0) ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (cnt == CNT_ONE) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Datapath: operand capture, shift stepping, result/zero load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg <= '0;
      cnt    <= '0;
      sh_op  <= '0;
      Result <= '0;
      Zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          if (is_shift(ALUControl)) begin
            sh_reg <= SrcA;
            cnt    <= shamt;
            sh_op  <= ALUControl;
            if (shamt == '0) begin
              Result <= SrcA;
              Zero   <= (SrcA == '0);
            end
          end else begin
            Result <= alu_y;
            Zero   <= (alu_y == '0);
          end
        end
        ST_SHIFT: begin
          sh_reg <= sh_nxt;
          cnt    <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            Result <= sh_nxt;
            Zero   <= (sh_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed vectors, decoupled monitor.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA, SrcB, Result;
  logic        in_valid, in_ready, Zero, out_valid, out_ready;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   seen = 1'b0;

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .Result     (Result),
    .Zero       (Zero),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop on first cycle of out_valid, check value and latency.
  always @(negedge clk) begin
    if (!rst_n) seen = 1'b0;
    else begin
      if (out_valid && !seen) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out: got Result=%h with no expected entry", Result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("result", Result, e.res);
          chk("zero", {31'b0, Zero}, {31'b0, e.z});
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
        seen = 1'b1;
      end
      if (out_valid && out_ready) seen = 1'b0;
      if (!out_valid && sb.size() > 0) chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic z, input int lat, input bit push);
    int n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL issue_timeout: in_ready stayed 0 for op %0d", op);
    end else begin
      ALUControl = op; SrcA = a; SrcB = b; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (push) sb.push_back('{res: r, z: z, lat: lat, acc: cyc});
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(sb.size() == 0 && in_ready) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL done_timeout: pending=%0d in_ready=%0b", sb.size(), in_ready);
      sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    ALUControl = '0; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", Result, 32'd0);
    chk("rst_zero", {31'b0, Zero}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Single-cycle ops.
    issue(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1, 1); wait_done();
    issue(ALU_SUB,  32'd5,        32'd5,        32'h00000000, 1'b1, 1, 1); wait_done();
    issue(ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1, 1); wait_done();
    issue(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1, 1); wait_done();
    issue(4'hC,     32'd3,        32'd4,        32'h00000007, 1'b0, 1, 1); wait_done();
    issue(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1, 1); wait_done();
    issue(ALU_XOR,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0, 1, 1); wait_done();

    // Shifts, including the max length and a shamt of zero with upper SrcB bits set.
    issue(ALU_SRA,  32'h80000000, 32'd31,       32'hFFFFFFFF, 1'b0, 32, 1); wait_done();
    issue(ALU_SRL,  32'h80000000, 32'd31,       32'h00000001, 1'b0, 32, 1); wait_done();
    issue(ALU_SLL,  32'h00000001, 32'hFFFFFFE0, 32'h00000001, 1'b0, 1, 1); wait_done();
    issue(ALU_SLL,  32'h00000001, 32'd4,        32'h00000010, 1'b0, 5, 1); wait_done();

    // Backpressure in DONE: outputs hold, no accept while a new request waits.
    out_ready = 1'b0;
    issue(ALU_OR, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1, 1);
    ALUControl = ALU_ADD; SrcA = 32'd1; SrcB = 32'd1; in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", Result, 32'h0F0F00F0);
      chk("hold_zero", {31'b0, Zero}, 32'd0);
      chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("release_out_valid", {31'b0, out_valid}, 32'd0);

    // Reset mid-shift discards the operation.
    issue(ALU_SLL, 32'h00000001, 32'd20, 32'h0, 1'b0, 0, 0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_result", Result, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    issue(ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1, 1); wait_done();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execution-side consumer of the 4-bit ALUControl code produced by the core's ALU decoder.
- Performs the ten RV32I ALU operations on two XLEN operands.
- ADD, SUB, AND, OR, XOR, SLT and SLTU complete in a single registered cycle.
- SLL, SRL and SRA are iterative: one bit position per cycle, to save area.
- Sits between the decode/operand-select stage and writeback, with valid/ready handshakes on both sides.

Parameters:
XLEN, 32, operand and result width.
SHAMT_W, 5, shift-amount width; equals log2(XLEN).

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
ALUControl  input  4  operation code: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, SLTU=6, XOR=7, SRL=8, SRA=9.
SrcA  input  XLEN  operand A; the value shifted for shift ops.
SrcB  input  XLEN  operand B; shift amount is SrcB[SHAMT_W-1:0].
in_valid  input  1  request valid.
in_ready  output  1  unit can accept a request.
Result  output  XLEN  registered result.
Zero  output  1  registered flag, Result==0.
out_valid  output  1  Result/Zero valid.
out_ready  input  1  downstream accepts the result.

Behaviour:
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE). Accept = in_valid && in_ready; ALUControl, SrcA and SrcB are sampled only on accept.
- Reset (async assert, any state): state=IDLE, Result=0, Zero=0, out_valid=0, internal shift register and counter=0. An in-flight operation is discarded; no output is produced for it.
- Non-shift op, or code 10–15 (treated as ADD): on the accept edge, Result and Zero are loaded and state goes to DONE. out_valid rises the cycle after accept (latency 1).
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN; no carry or overflow output.
  - SLT is a signed compare and SLTU an unsigned compare; each gives Result = {XLEN-1 zeros, lt}.
  - AND, OR and XOR are bitwise.
- Shift op with shamt n:
  - On accept, SrcA loads the shift register and n loads the counter.
  - If n==0: Result=SrcA and go to DONE (latency 1).
  - Otherwise go to SHIFT. Each SHIFT cycle shifts by exactly one bit and decrements the counter:
    - SLL: shift left, zero-fill.
    - SRL: shift right, zero-fill.
    - SRA: shift right, replicate the MSB.
  - On the cycle the counter reaches 0, Result and Zero are loaded from the final value and state goes to DONE.
  - Total latency is 1+n cycles from the accept edge to out_valid; the maximum is 32 for n=31.
- Only SrcB[SHAMT_W-1:0] is used; upper SrcB bits are ignored for shifts.
- DONE: out_valid=1. Result and Zero are held stable until out_valid && out_ready, then state returns to IDLE.
- Back-to-back throughput: a new request is accepted at the earliest one cycle after the handshake. No accept occurs in DONE, even if out_ready is high.
- in_valid deasserting while in SHIFT or DONE has no effect, since the operands are already captured.
- out_ready high before out_valid has no effect.
- Zero is computed from the value being loaded into Result, not from the shift register.

Decomposition:
- Shared package alu_pkg: ALU_ADD..ALU_SRA localparams (4-bit codes 0–9), identical to the decoder's encoding. The decoder and this unit both import it; no duplicate definitions.
- One combinational sub-module, alu_single_cycle: ADD, SUB, AND, OR, XOR, SLT, SLTU and the default case.
- FSM, shift register and counter stay in alu_exec_unit.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 -> out_valid the cycle after accept, Result=0x80000000, Zero=0; SUB 5-5 -> Result=0, Zero=1.
- SLT 0xFFFFFFFF vs 0x00000001 -> Result=1; SLTU with the same operands -> Result=0; code 4'hC with 3,4 -> Result=7 (ADD).
- SRA 0x80000000 by 31 -> out_valid exactly 32 cycles after accept, Result=0xFFFFFFFF; SRL with the same operands -> Result=0x00000001; in_ready=0 throughout.
- SLL 0x00000001 with SrcB=0xFFFFFFE0 (shamt 0) -> latency 1, Result=0x00000001; SLL by 4 -> latency 5, Result=0x00000010.
- Hold out_ready=0 for 10 cycles in DONE -> Result, Zero and out_valid stable and no new accept; out_ready=1 -> IDLE next cycle, in_ready=1.
- Assert rst_n=0 mid-SHIFT (SLL by 20, after 7 cycles) -> out_valid=0 and state IDLE immediately; after release, the next ADD 2+2 -> Result=4 with latency 1.
